// File: rtl/dual_seg_mux_ctrl.sv
// dual_seg_mux_ctrl
// Drives one shared active-low 7-segment bus across two common-anode digits.
// Each frame is BLANK0 -> SHOW0 -> BLANK1 -> SHOW1. A blanking gap comes
// before each lit slot so segments never bleed from one digit into the next.
// The hex nibble for a digit is captured when its slot starts and held for
// the whole slot. All outputs come straight from flops.

module dual_seg_mux_ctrl #(
    parameter int SHOW_CYCLES  = 48000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int MAX_DUR = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int TIMER_W = $clog2(MAX_DUR);

    // Terminal counts: a timed state leaves on the edge where timer hits DUR-1,
    // so the timer never needs to wrap.
    localparam logic [TIMER_W-1:0] SHOW_LAST  = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_BLANK0 = 3'd1;
    localparam logic [2:0] ST_SHOW0  = 3'd2;
    localparam logic [2:0] ST_BLANK1 = 3'd3;
    localparam logic [2:0] ST_SHOW1  = 3'd4;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_D0   = 2'b10;
    localparam logic [1:0] AN_D1   = 2'b01;

    // Hex to active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    logic [2:0]         state_r;
    logic [2:0]         state_nxt_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_nxt_s;
    logic [3:0]         nibble_r;
    logic [3:0]         nibble_nxt_s;
    logic               tick_nxt_s;
    logic [6:0]         seg_nxt_s;
    logic [1:0]         an_nxt_s;

    // Next-state, timer, digit capture and end-of-frame detection.
    always_comb begin
        state_nxt_s  = state_r;
        timer_nxt_s  = timer_r + TIMER_ONE;
        nibble_nxt_s = nibble_r;
        tick_nxt_s   = 1'b0;
        if (!en) begin
            // Dropping enable abandons the frame; no tick for a cut frame.
            state_nxt_s = ST_IDLE;
            timer_nxt_s = TIMER_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_BLANK0;
                    timer_nxt_s = TIMER_ZERO;
                end
                ST_BLANK0: begin
                    if (timer_r == BLANK_LAST) begin
                        state_nxt_s  = ST_SHOW0;
                        timer_nxt_s  = TIMER_ZERO;
                        nibble_nxt_s = s0;
                    end else begin
                        state_nxt_s  = ST_BLANK0;
                    end
                end
                ST_SHOW0: begin
                    if (timer_r == SHOW_LAST) begin
                        state_nxt_s = ST_BLANK1;
                        timer_nxt_s = TIMER_ZERO;
                    end else begin
                        state_nxt_s = ST_SHOW0;
                    end
                end
                ST_BLANK1: begin
                    if (timer_r == BLANK_LAST) begin
                        state_nxt_s  = ST_SHOW1;
                        timer_nxt_s  = TIMER_ZERO;
                        nibble_nxt_s = s1;
                    end else begin
                        state_nxt_s  = ST_BLANK1;
                    end
                end
                ST_SHOW1: begin
                    if (timer_r == SHOW_LAST) begin
                        state_nxt_s = ST_BLANK0;
                        timer_nxt_s = TIMER_ZERO;
                        tick_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_SHOW1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = TIMER_ZERO;
                end
            endcase
        end
    end

    // Output values derived from the upcoming state so the registered outputs
    // line up with the state register.
    always_comb begin
        an_nxt_s  = AN_OFF;
        seg_nxt_s = SEG_OFF;
        case (state_nxt_s)
            ST_SHOW0: begin
                an_nxt_s  = AN_D0;
                seg_nxt_s = hex_to_seg(nibble_nxt_s);
            end
            ST_SHOW1: begin
                an_nxt_s  = AN_D1;
                seg_nxt_s = hex_to_seg(nibble_nxt_s);
            end
            default: begin
                an_nxt_s  = AN_OFF;
                seg_nxt_s = SEG_OFF;
            end
        endcase
    end

    // State, timer, captured nibble and registered outputs; reset blanks at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_BLANK0;
            timer_r    <= TIMER_ZERO;
            nibble_r   <= 4'h0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            timer_r    <= timer_nxt_s;
            nibble_r   <= nibble_nxt_s;
            an         <= an_nxt_s;
            seg        <= seg_nxt_s;
            frame_tick <= tick_nxt_s;
        end
    end

endmodule
